sitcpxg_tx_seq_checker: RTL and testbench

//  Passive checker on the SiTCPXG TX byte stream (TX_D/TX_B) produced by tcp_test.

---
 rtl/sitcpxg_tx_seq_checker.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_sitcpxg_tx_seq_checker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sitcpxg_tx_seq_checker.sv
// sitcpxg_tx_seq_checker
// Passive checker for the SiTCPXG TX byte stream. It rebuilds the expected
// byte sequence, either incrementing bytes seeded from the first beat or a
// repeating 32-bit pattern. It counts checked bytes and the beats that hold a
// mismatch, and it flags completion once NUM_OF_DATA bytes have been consumed.
// Optional feature macro: SEQ_CHK_ERR_CAPTURE_EN adds the first-error capture
// outputs FIRST_ERR_POS, FIRST_ERR_EXP and FIRST_ERR_DAT.
module sitcpxg_tx_seq_checker #(
  parameter int ERR_CNT_W = 32
) (
  input  logic                 CLK156M,
  input  logic                 RSTs,
  input  logic                 ENABLE,
  input  logic                 SiTCPXG_ESTABLISHED,
  input  logic                 SELECT_SEQ,
  input  logic [31:0]          SEQ_PATTERN,
  input  logic [63:0]          NUM_OF_DATA,
  input  logic                 CLR_STAT,
  input  logic [63:0]          SiTCPXG_TX_D,
  input  logic [3:0]           SiTCPXG_TX_B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [63:0]          BYTE_CNT,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic                 ERR_FLAG,
  output logic                 PROTO_ERR
`ifdef SEQ_CHK_ERR_CAPTURE_EN
  ,
  output logic [63:0]          FIRST_ERR_POS,
  output logic [63:0]          FIRST_ERR_EXP,
  output logic [63:0]          FIRST_ERR_DAT
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  // Pattern byte selected by the running byte index (byte0 is the MSB).
  function automatic logic [7:0] pat_byte(input logic [31:0] pat, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = pat[31:24];
      2'd1:    b = pat[23:16];
      2'd2:    b = pat[15:8];
      2'd3:    b = pat[7:0];
      default: b = pat[7:0];
    endcase
    return b;
  endfunction

  state_t                 state_q, state_d;
  logic [7:0]             k_q, k_d;
  logic [7:0]             seed_q, seed_d;
  logic [63:0]            byte_cnt_q, byte_cnt_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   err_flag_q, err_flag_d;
  logic                   proto_q, proto_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
`ifdef SEQ_CHK_ERR_CAPTURE_EN
  logic                   cap_q, cap_d;
  logic [63:0]            cap_pos_q, cap_pos_d;
  logic [63:0]            cap_exp_q, cap_exp_d;
  logic [63:0]            cap_dat_q, cap_dat_d;
`endif

  logic                   active_s;
  logic                   valid_beat_s;
  logic                   accept_s;
  logic [63:0]            rem_s;
  logic [3:0]             n_chk_s;
  logic [7:0]             base_s;
  logic [63:0]            exp_beat_s;
  logic [63:0]            rx_beat_s;
  logic                   mismatch_s;

  assign active_s     = (state_q == ST_SYNC) || (state_q == ST_CHECK);
  assign valid_beat_s = (SiTCPXG_TX_B != 4'd0) && (SiTCPXG_TX_B <= 4'd8);
  assign accept_s     = active_s && valid_beat_s && !CLR_STAT;

  // Number of bytes of this beat that still fall inside NUM_OF_DATA.
  always_comb begin
    rem_s   = 64'd0;
    n_chk_s = 4'd0;
    if (NUM_OF_DATA == 64'd0) begin
      n_chk_s = SiTCPXG_TX_B;
    end else if (byte_cnt_q >= NUM_OF_DATA) begin
      n_chk_s = 4'd0;
    end else begin
      rem_s = NUM_OF_DATA - byte_cnt_q;
      if (rem_s < {60'd0, SiTCPXG_TX_B}) begin
        n_chk_s = rem_s[3:0];
      end else begin
        n_chk_s = SiTCPXG_TX_B;
      end
    end
  end

  // Expected and received beats, with the unchecked byte lanes forced to zero.
  always_comb begin
    exp_beat_s = 64'd0;
    rx_beat_s  = 64'd0;
    // While in SYNC, byte0 of the beat is the seed, so the first beat
    // is checked against itself.
    if ((state_q == ST_SYNC) && !SELECT_SEQ) begin
      base_s = SiTCPXG_TX_D[63:56];
    end else begin
      base_s = seed_q + k_q;
    end
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < n_chk_s) begin
        if (SELECT_SEQ) begin
          exp_beat_s[63-8*i -: 8] = pat_byte(SEQ_PATTERN, k_q[1:0] + 2'(i));
        end else begin
          exp_beat_s[63-8*i -: 8] = base_s + 8'(i);
        end
        rx_beat_s[63-8*i -: 8] = SiTCPXG_TX_D[63-8*i -: 8];
      end else begin
        exp_beat_s[63-8*i -: 8] = 8'd0;
        rx_beat_s[63-8*i -: 8]  = 8'd0;
      end
    end
    mismatch_s = (exp_beat_s != rx_beat_s);
  end

  // Next-state computation for the FSM, the byte index and the statistics.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    seed_d     = seed_q;
    byte_cnt_d = byte_cnt_q;
    err_cnt_d  = err_cnt_q;
    proto_d    = proto_q;
`ifdef SEQ_CHK_ERR_CAPTURE_EN
    cap_d      = cap_q;
    cap_pos_d  = cap_pos_q;
    cap_exp_d  = cap_exp_q;
    cap_dat_d  = cap_dat_q;
`endif

    // The byte index advances by the full beat so that one corrupted
    // beat never causes a resync or a cascade of errors.
    if (accept_s) begin
      byte_cnt_d = byte_cnt_q + {60'd0, n_chk_s};
      k_d        = k_q + {4'd0, SiTCPXG_TX_B};
      if ((state_q == ST_SYNC) && !SELECT_SEQ) begin
        seed_d = SiTCPXG_TX_D[63:56];
      end else begin
        seed_d = seed_q;
      end
      if (mismatch_s && (err_cnt_q != ERR_MAX)) begin
        err_cnt_d = err_cnt_q + ERR_ONE;
      end else begin
        err_cnt_d = err_cnt_q;
      end
`ifdef SEQ_CHK_ERR_CAPTURE_EN
      if (mismatch_s && !cap_q) begin
        cap_d     = 1'b1;
        cap_pos_d = byte_cnt_q;
        cap_exp_d = exp_beat_s;
        cap_dat_d = rx_beat_s;
      end else begin
        cap_d     = cap_q;
      end
`endif
    end else begin
      byte_cnt_d = byte_cnt_q;
    end

    if (active_s && (SiTCPXG_TX_B > 4'd8) && !CLR_STAT) begin
      proto_d = 1'b1;
    end else begin
      proto_d = proto_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (ENABLE && SiTCPXG_ESTABLISHED) begin
          state_d = ST_SYNC;
          k_d     = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC, ST_CHECK: begin
        if (!ENABLE || !SiTCPXG_ESTABLISHED) begin
          state_d = ST_IDLE;
        end else if (CLR_STAT) begin
          state_d = state_q;
        end else if (accept_s) begin
          if ((NUM_OF_DATA != 64'd0) && (byte_cnt_d >= NUM_OF_DATA)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CHECK;
          end
        end else if ((state_q == ST_CHECK) && (NUM_OF_DATA != 64'd0) &&
                     (byte_cnt_q >= NUM_OF_DATA)) begin
          state_d = ST_DONE;
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: begin
        if (!ENABLE || !SiTCPXG_ESTABLISHED) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A clear pulse wipes the statistics and drops a coincident beat.
    if (CLR_STAT) begin
      byte_cnt_d = 64'd0;
      err_cnt_d  = {ERR_CNT_W{1'b0}};
      proto_d    = 1'b0;
`ifdef SEQ_CHK_ERR_CAPTURE_EN
      cap_d      = 1'b0;
      cap_pos_d  = 64'd0;
      cap_exp_d  = 64'd0;
      cap_dat_d  = 64'd0;
`endif
    end else begin
      byte_cnt_d = byte_cnt_d;
    end

    if (CLR_STAT) begin
      done_d = 1'b0;
    end else if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      done_d = 1'b1;
    end else begin
      done_d = done_q;
    end

    err_flag_d = (err_cnt_d != {ERR_CNT_W{1'b0}});
    busy_d     = (state_d == ST_SYNC) || (state_d == ST_CHECK);
  end

  // State and statistics registers with synchronous reset.
  always_ff @(posedge CLK156M) begin
    if (RSTs) begin
      state_q    <= ST_IDLE;
      k_q        <= 8'd0;
      seed_q     <= 8'd0;
      byte_cnt_q <= 64'd0;
      err_cnt_q  <= {ERR_CNT_W{1'b0}};
      err_flag_q <= 1'b0;
      proto_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SEQ_CHK_ERR_CAPTURE_EN
      cap_q      <= 1'b0;
      cap_pos_q  <= 64'd0;
      cap_exp_q  <= 64'd0;
      cap_dat_q  <= 64'd0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      seed_q     <= seed_d;
      byte_cnt_q <= byte_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      proto_q    <= proto_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
`ifdef SEQ_CHK_ERR_CAPTURE_EN
      cap_q      <= cap_d;
      cap_pos_q  <= cap_pos_d;
      cap_exp_q  <= cap_exp_d;
      cap_dat_q  <= cap_dat_d;
`endif
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign BYTE_CNT  = byte_cnt_q;
  assign ERR_CNT   = err_cnt_q;
  assign ERR_FLAG  = err_flag_q;
  assign PROTO_ERR = proto_q;
`ifdef SEQ_CHK_ERR_CAPTURE_EN
  assign FIRST_ERR_POS = cap_pos_q;
  assign FIRST_ERR_EXP = cap_exp_q;
  assign FIRST_ERR_DAT = cap_dat_q;
`endif

endmodule

// File: tb/tb_sitcpxg_tx_seq_checker.sv
// Testbench for sitcpxg_tx_seq_checker: directed scenarios plus randomized
// traffic. A behavioural model predicts the outputs for every clock and queues
// them, and a monitor compares each queued prediction with the DUT outputs.
module tb_sitcpxg_tx_seq_checker;

  logic        clk = 1'b0;
  logic        RSTs, ENABLE, SiTCPXG_ESTABLISHED, SELECT_SEQ, CLR_STAT;
  logic [31:0] SEQ_PATTERN;
  logic [63:0] NUM_OF_DATA, SiTCPXG_TX_D;
  logic [3:0]  SiTCPXG_TX_B;
  logic        BUSY, DONE, ERR_FLAG, PROTO_ERR;
  logic [63:0] BYTE_CNT;
  logic [31:0] ERR_CNT;
`ifdef SEQ_CHK_ERR_CAPTURE_EN
  logic [63:0] FIRST_ERR_POS, FIRST_ERR_EXP, FIRST_ERR_DAT;
`endif

  always #5 clk = ~clk;

  sitcpxg_tx_seq_checker #(.ERR_CNT_W(32)) dut (
    .CLK156M(clk), .RSTs(RSTs), .ENABLE(ENABLE),
    .SiTCPXG_ESTABLISHED(SiTCPXG_ESTABLISHED), .SELECT_SEQ(SELECT_SEQ),
    .SEQ_PATTERN(SEQ_PATTERN), .NUM_OF_DATA(NUM_OF_DATA), .CLR_STAT(CLR_STAT),
    .SiTCPXG_TX_D(SiTCPXG_TX_D), .SiTCPXG_TX_B(SiTCPXG_TX_B),
    .BUSY(BUSY), .DONE(DONE), .BYTE_CNT(BYTE_CNT), .ERR_CNT(ERR_CNT),
    .ERR_FLAG(ERR_FLAG), .PROTO_ERR(PROTO_ERR)
`ifdef SEQ_CHK_ERR_CAPTURE_EN
    , .FIRST_ERR_POS(FIRST_ERR_POS), .FIRST_ERR_EXP(FIRST_ERR_EXP),
    .FIRST_ERR_DAT(FIRST_ERR_DAT)
`endif
  );

  typedef struct {
    logic        busy, done, err_flag, proto;
    logic [63:0] cnt;
    logic [31:0] err;
    logic [63:0] cpos, cexp, cdat;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // configuration staged by the stimulus, applied to the DUT inside step()
  logic        cfg_en = 1'b0, cfg_est = 1'b0, cfg_sel = 1'b0;
  logic [31:0] cfg_pat = 32'd0;
  logic [63:0] cfg_num = 64'd0;

  // generator stream position
  logic [7:0]  g_seed = 8'd0;
  int unsigned g_pos  = 0;

  // behavioural model state
  bit              m_sess, m_first, m_fin, m_done, m_perr, m_cap;
  longint unsigned m_cnt, m_err;
  int unsigned     m_pos;
  logic [7:0]      m_seed;
  logic [63:0]     m_cpos, m_cexp, m_cdat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] patb(input logic [31:0] p, input int unsigned pos);
    logic [31:0] s;
    s = p >> (8 * (3 - (pos % 4)));
    return s[7:0];
  endfunction

  function automatic logic [7:0] exp_byte(input int unsigned pos);
    logic [31:0] v;
    v = 32'(m_seed) + 32'(pos);
    return cfg_sel ? patb(cfg_pat, pos) : v[7:0];
  endfunction

  function automatic logic [7:0] gen_byte(input int unsigned pos);
    logic [31:0] v;
    v = 32'(g_seed) + 32'(pos);
    return cfg_sel ? patb(cfg_pat, pos) : v[7:0];
  endfunction

  // Predict the outputs after the coming clock edge from the inputs just applied.
  task automatic model_step();
    bit checking, was_check, leaving, acc, bad;
    int n;
    logic [63:0] eb, rb;
    exp_t e;
    acc = 1'b0;
    if (RSTs) begin
      m_sess = 0; m_first = 0; m_fin = 0; m_done = 0; m_perr = 0; m_cap = 0;
      m_cnt = 0; m_err = 0; m_pos = 0; m_seed = 8'd0;
      m_cpos = 64'd0; m_cexp = 64'd0; m_cdat = 64'd0;
    end else begin
      checking  = m_sess && !m_fin;
      was_check = checking && m_first;
      leaving   = m_sess && !(ENABLE && SiTCPXG_ESTABLISHED);
      if (checking && !CLR_STAT && SiTCPXG_TX_B >= 4'd1 && SiTCPXG_TX_B <= 4'd8) begin
        acc = 1'b1;
        if (!m_first && !cfg_sel) m_seed = SiTCPXG_TX_D[63:56];
        if (cfg_num == 0) n = int'(SiTCPXG_TX_B);
        else if (m_cnt >= cfg_num) n = 0;
        else if (cfg_num - m_cnt < 64'(SiTCPXG_TX_B)) n = int'(cfg_num - m_cnt);
        else n = int'(SiTCPXG_TX_B);
        eb = 64'd0; rb = 64'd0;
        for (int i = 0; i < n; i++) begin
          eb[63-8*i -: 8] = exp_byte(m_pos + i);
          rb[63-8*i -: 8] = SiTCPXG_TX_D[63-8*i -: 8];
        end
        bad = (eb != rb);
        if (bad && !m_cap) begin
          m_cap = 1; m_cpos = m_cnt; m_cexp = eb; m_cdat = rb;
        end
        m_cnt = m_cnt + longint'(n);
        if (bad && m_err != 64'h0000_0000_FFFF_FFFF) m_err = m_err + 1;
        m_pos = m_pos + int'(SiTCPXG_TX_B);
        m_first = 1'b1;
      end else if (checking && !CLR_STAT && SiTCPXG_TX_B > 4'd8) begin
        m_perr = 1'b1;
      end
      if (CLR_STAT) begin
        m_cnt = 0; m_err = 0; m_perr = 0; m_done = 0; m_cap = 0;
        m_cpos = 64'd0; m_cexp = 64'd0; m_cdat = 64'd0;
      end
      if (leaving) begin
        m_sess = 0; m_fin = 0;
      end else if (!m_sess) begin
        if (ENABLE && SiTCPXG_ESTABLISHED) begin
          m_sess = 1; m_first = 0; m_fin = 0; m_pos = 0;
        end
      end else if (checking && !CLR_STAT && (acc || was_check) && cfg_num != 0 && m_cnt >= cfg_num) begin
        m_fin = 1; m_done = 1;
      end
    end
    e.busy = m_sess && !m_fin; e.done = m_done; e.err_flag = (m_err != 0);
    e.proto = m_perr; e.cnt = m_cnt; e.err = m_err[31:0];
    e.cpos = m_cpos; e.cexp = m_cexp; e.cdat = m_cdat;
    q.push_back(e);
  endtask

  // Apply one cycle of stimulus shortly after the clock edge and queue the prediction.
  task automatic step(input logic r, input logic c, input logic [3:0] b, input logic [63:0] d);
    @(posedge clk);
    #2;
    RSTs = r; CLR_STAT = c; SiTCPXG_TX_B = b; SiTCPXG_TX_D = d;
    ENABLE = cfg_en; SiTCPXG_ESTABLISHED = cfg_est; SELECT_SEQ = cfg_sel;
    SEQ_PATTERN = cfg_pat; NUM_OF_DATA = cfg_num;
    model_step();
  endtask

  task automatic step_idle();
    step(1'b0, 1'b0, 4'd0, {$urandom, $urandom});
  endtask

  // Send nb correct stream bytes; lanes flagged in cm are inverted.
  task automatic send_beat(input int nb, input logic [7:0] cm, input logic c);
    logic [63:0] d;
    d = {$urandom, $urandom};
    for (int i = 0; i < nb; i++) begin
      d[63-8*i -: 8] = gen_byte(g_pos + i) ^ (cm[i] ? 8'hFF : 8'h00);
    end
    step(1'b0, c, 4'(nb), d);
    g_pos = g_pos + nb;
  endtask

  task automatic stop_and_clear();
    cfg_en = 1'b0;
    step_idle();
    step(1'b0, 1'b1, 4'd0, 64'd0);
    step_idle();
  endtask

  // Monitor: compare each queued prediction just after the edge it refers to.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("busy", {63'd0, BUSY}, {63'd0, e.busy});
      chk("done", {63'd0, DONE}, {63'd0, e.done});
      chk("byte_cnt", BYTE_CNT, e.cnt);
      chk("err_cnt", {32'd0, ERR_CNT}, {32'd0, e.err});
      chk("err_flag", {63'd0, ERR_FLAG}, {63'd0, e.err_flag});
      chk("proto_err", {63'd0, PROTO_ERR}, {63'd0, e.proto});
`ifdef SEQ_CHK_ERR_CAPTURE_EN
      chk("first_err_pos", FIRST_ERR_POS, e.cpos);
      chk("first_err_exp", FIRST_ERR_EXP, e.cexp);
      chk("first_err_dat", FIRST_ERR_DAT, e.cdat);
`endif
    end
  end

  initial begin
    int r, nb;
    logic [7:0] cm;
    RSTs = 1'b1; ENABLE = 1'b0; SiTCPXG_ESTABLISHED = 1'b0; SELECT_SEQ = 1'b0;
    SEQ_PATTERN = 32'd0; NUM_OF_DATA = 64'd0; CLR_STAT = 1'b0;
    SiTCPXG_TX_D = 64'd0; SiTCPXG_TX_B = 4'd0;

    step(1'b1, 1'b0, 4'd0, 64'd0);
    step_idle();

    // 1: clean incrementing stream of 640 bytes
    cfg_sel = 1'b0; cfg_num = 64'd640; g_seed = 8'h00; g_pos = 0;
    cfg_en = 1'b1; cfg_est = 1'b1; step_idle();
    for (int bt = 0; bt < 80; bt++) begin
      send_beat(8, 8'h00, 1'b0);
      if ($urandom_range(0, 3) == 0) step_idle();
    end
    step_idle(); step_idle();
    chk("t1_byte_cnt", BYTE_CNT, 64'd640);
    chk("t1_done", {63'd0, DONE}, 64'd1);
    chk("t1_err_cnt", {32'd0, ERR_CNT}, 64'd0);
    stop_and_clear();

    // 2: byte3 of beat 10 corrupted
    g_seed = 8'h00; g_pos = 0; cfg_en = 1'b1; step_idle();
    for (int bt = 0; bt < 80; bt++) begin
      send_beat(8, (bt == 10) ? 8'h08 : 8'h00, 1'b0);
    end
    step_idle(); step_idle();
    chk("t2_err_cnt", {32'd0, ERR_CNT}, 64'd1);
    chk("t2_err_flag", {63'd0, ERR_FLAG}, 64'd1);
    chk("t2_done", {63'd0, DONE}, 64'd1);
`ifdef SEQ_CHK_ERR_CAPTURE_EN
    chk("t2_first_err_pos", FIRST_ERR_POS, 64'd80);
`endif
    stop_and_clear();

    // 3: pattern mode, beats of 3, 8 and 5 bytes
    cfg_sel = 1'b1; cfg_pat = 32'h6080_8040; cfg_num = 64'd0; g_pos = 0;
    cfg_en = 1'b1; step_idle();
    send_beat(3, 8'h00, 1'b0);
    send_beat(8, 8'h00, 1'b0);
    step_idle();
    send_beat(5, 8'h00, 1'b0);
    step_idle(); step_idle();
    chk("t3_byte_cnt", BYTE_CNT, 64'd16);
    chk("t3_err_cnt", {32'd0, ERR_CNT}, 64'd0);
    stop_and_clear();

    // 4: final beat truncated, corrupt bytes beyond NUM_OF_DATA ignored
    cfg_sel = 1'b0; cfg_num = 64'd10; g_seed = 8'($urandom); g_pos = 0;
    cfg_en = 1'b1; step_idle();
    send_beat(8, 8'h00, 1'b0);
    send_beat(8, 8'hFC, 1'b0);
    step_idle(); step_idle();
    chk("t4_byte_cnt", BYTE_CNT, 64'd10);
    chk("t4_err_cnt", {32'd0, ERR_CNT}, 64'd0);
    chk("t4_done", {63'd0, DONE}, 64'd1);
    stop_and_clear();

    // 5: session drop and re-seed at 0x37, counters keep accumulating
    cfg_num = 64'd0; g_seed = 8'h10; g_pos = 0; cfg_en = 1'b1; step_idle();
    for (int bt = 0; bt < 5; bt++) send_beat(8, 8'h00, 1'b0);
    cfg_est = 1'b0; step_idle();
    cfg_est = 1'b1; step_idle();
    g_seed = 8'h37; g_pos = 0;
    for (int bt = 0; bt < 3; bt++) send_beat(8, 8'h00, 1'b0);
    step_idle(); step_idle();
    chk("t5_byte_cnt", BYTE_CNT, 64'd64);
    chk("t5_err_cnt", {32'd0, ERR_CNT}, 64'd0);
    chk("t5_busy", {63'd0, BUSY}, 64'd1);

    // 6: illegal byte count, then clear
    step(1'b0, 1'b0, 4'd12, {$urandom, $urandom});
    step_idle();
    chk("t6_proto_err", {63'd0, PROTO_ERR}, 64'd1);
    chk("t6_byte_cnt", BYTE_CNT, 64'd64);
    step(1'b0, 1'b1, 4'd0, 64'd0);
    step_idle();
    chk("t6_clr_byte_cnt", BYTE_CNT, 64'd0);
    chk("t6_clr_proto", {63'd0, PROTO_ERR}, 64'd0);
    chk("t6_clr_err_flag", {63'd0, ERR_FLAG}, 64'd0);
    stop_and_clear();

    // randomized sessions
    for (int run = 0; run < 12; run++) begin
      cfg_sel = 1'($urandom_range(0, 1));
      cfg_pat = $urandom;
      cfg_num = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 150));
      g_seed = 8'($urandom); g_pos = 0;
      cfg_en = 1'b1; cfg_est = 1'b1; step_idle();
      for (int it = 0; it < 60; it++) begin
        r = $urandom_range(0, 99);
        if (r < 60) begin
          nb = $urandom_range(1, 8); cm = 8'h00;
          if ($urandom_range(0, 9) == 0) cm[$urandom_range(0, nb - 1)] = 1'b1;
          send_beat(nb, cm, 1'b0);
        end else if (r < 72) begin
          step_idle();
        end else if (r < 75) begin
          step(1'b0, 1'b0, 4'($urandom_range(9, 15)), {$urandom, $urandom});
        end else if (r < 78) begin
          send_beat($urandom_range(1, 8), 8'h00, 1'b1);
        end else if (r < 81) begin
          cfg_est = 1'b0; step_idle();
          cfg_est = 1'b1; step_idle();
          g_seed = 8'($urandom); g_pos = 0;
        end else if (r < 83) begin
          step(1'b1, 1'b0, 4'd0, 64'd0);
          step_idle();
          g_pos = 0;
        end else begin
          step_idle();
        end
      end
      cfg_en = 1'b0; step_idle();
      if ($urandom_range(0, 1) == 1) step(1'b0, 1'b1, 4'd0, 64'd0);
      step_idle();
    end

    @(posedge clk);
    #3;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
